// File: rtl/i2c_eeprom_slave_pkg.sv
// Shared types and constants for the serial EEPROM responder.
// State encoding, array geometry and the default device address.
package eeprom_pkg;

  localparam int EEPROM_ADDR_W = 13;
  localparam int EEPROM_DEPTH  = 8192;

  localparam logic [6:0] EEPROM_DEV_ADDR = 7'b1010000;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    ADDR_HI,
    ACK_HI,
    ADDR_LO,
    ACK_LO,
    WDATA,
    WACK,
    RDATA,
    RACK,
    IGNORE
  } eeprom_state_t;

  // Advance only the bits under mask, wrapping inside the write page.
  function automatic logic [EEPROM_ADDR_W-1:0] page_inc(
    input logic [EEPROM_ADDR_W-1:0] a,
    input logic [EEPROM_ADDR_W-1:0] mask
  );
    logic [EEPROM_ADDR_W-1:0] nxt;
    nxt = a + 1'b1;
    return (a & ~mask) | (nxt & mask);
  endfunction

endpackage

// File: rtl/i2c_eeprom_slave_if.sv
// Two-wire bus pins (scl, sda_in, sda_out) and host array port
// (host_addr, host_we, host_wdata, host_rdata) of the EEPROM.
interface i2c_eeprom_slave_if;
  import eeprom_pkg::*;

  logic                     scl;
  logic                     sda_in;
  logic                     sda_out;
  logic [EEPROM_ADDR_W-1:0] host_addr;
  logic                     host_we;
  logic [7:0]               host_wdata;
  logic [7:0]               host_rdata;

  modport master (
    output scl,
    output sda_in,
    output host_addr,
    output host_we,
    output host_wdata,
    input  sda_out,
    input  host_rdata
  );

  modport slave (
    input  scl,
    input  sda_in,
    input  host_addr,
    input  host_we,
    input  host_wdata,
    output sda_out,
    output host_rdata
  );

endinterface

// File: rtl/i2c_eeprom_slave_mem.sv
// 8192x8 dual-port array: port A serial write + async read,
// port B host write + registered read (b_rdata). A wins on collision.
module eeprom_mem
  import eeprom_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_we,
  input  logic [EEPROM_ADDR_W-1:0] a_addr,
  input  logic [7:0]               a_wdata,
  output logic [7:0]               a_rdata,
  input  logic                     b_we,
  input  logic [EEPROM_ADDR_W-1:0] b_addr,
  input  logic [7:0]               b_wdata,
  output logic [7:0]               b_rdata
);

  logic [7:0] mem [EEPROM_DEPTH];
  logic       b_we_ok;

  // Host write is dropped when the serial side hits the same byte.
  assign b_we_ok = b_we && !(a_we && (a_addr == b_addr));

  always_ff @(posedge clk) begin
    if (a_we)
      mem[a_addr] <= a_wdata;
    if (b_we_ok)
      mem[b_addr] <= b_wdata;
  end

  assign a_rdata = mem[a_addr];

  always_ff @(posedge clk) begin
    if (!reset)
      b_rdata <= '0;
    else
      b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 64 Kbit two-wire EEPROM responder: start/stop, device byte,
// 13-bit word address, page writes, sequential reads, host port.
module i2c_eeprom_slave
  import eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = EEPROM_DEV_ADDR,
  parameter int         PAGE_BITS = 5
) (
  input  logic              clk,
  input  logic              reset,
  i2c_eeprom_slave_if.slave bus
);

  localparam logic [EEPROM_ADDR_W-1:0] PAGE_MASK =
    EEPROM_ADDR_W'((1 << PAGE_BITS) - 1);

  logic scl_q, scl_qq;
  logic sda_q, sda_qq;
  logic rise_q, fall_q;
  logic start_q, stop_q;
  logic bit_q;

  eeprom_state_t state, state_d;

  logic [EEPROM_ADDR_W-1:0] addr, addr_d;
  logic [3:0]               cnt, cnt_d;
  logic [7:0]               sh, sh_d;
  logic                     sda_r, sda_d;
  logic                     mem_we;
  logic [7:0]               rd_data;
  logic [7:0]               wr_byte;
  logic                     last_bit;
  logic                     byte_done;

  // Edge/condition pulses are registered, so the FSM acts on the
  // third clk after a raw pin change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_q   <= 1'b1;
      scl_qq  <= 1'b1;
      sda_q   <= 1'b1;
      sda_qq  <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      bit_q   <= 1'b1;
    end else begin
      scl_q   <= bus.scl;
      scl_qq  <= scl_q;
      sda_q   <= bus.sda_in;
      sda_qq  <= sda_q;
      rise_q  <= scl_q & ~scl_qq;
      fall_q  <= ~scl_q & scl_qq;
      start_q <= scl_q & scl_qq & sda_qq & ~sda_q;
      stop_q  <= scl_q & scl_qq & ~sda_qq & sda_q;
      bit_q   <= sda_q;
    end
  end

  assign wr_byte   = {sh[6:0], bit_q};
  assign last_bit  = (cnt == 4'd7);
  assign byte_done = (cnt == 4'd8);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      sh    <= '0;
      sda_r <= 1'b1;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      cnt   <= cnt_d;
      sh    <= sh_d;
      sda_r <= sda_d;
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = addr;
    cnt_d   = cnt;
    sh_d    = sh;
    sda_d   = sda_r;
    mem_we  = 1'b0;
    if (start_q) begin
      state_d = DEV;
      cnt_d   = '0;
      sda_d   = 1'b1;
    end else if (stop_q) begin
      state_d = IDLE;
      cnt_d   = '0;
      sda_d   = 1'b1;
    end else begin
      unique case (state)
        DEV, ADDR_HI, ADDR_LO, WDATA: begin
          if (rise_q && !byte_done) begin
            sh_d  = wr_byte;
            cnt_d = cnt + 4'd1;
            if (state == WDATA && last_bit) begin
              mem_we = 1'b1;
              addr_d = page_inc(addr, PAGE_MASK);
            end
          end
          if (fall_q && byte_done) begin
            cnt_d = '0;
            sda_d = 1'b0;
            if (state == DEV) begin
              if (sh[7:1] == DEV_ADDR) begin
                state_d = DEV_ACK;
              end else begin
                state_d = IGNORE;
                sda_d   = 1'b1;
              end
            end else if (state == ADDR_HI) begin
              addr_d[12:8] = sh[4:0];
              state_d      = ACK_HI;
            end else if (state == ADDR_LO) begin
              addr_d[7:0] = sh;
              state_d     = ACK_LO;
            end else begin
              state_d = WACK;
            end
          end
        end
        DEV_ACK: begin
          if (fall_q) begin
            cnt_d = '0;
            sda_d = 1'b1;
            if (sh[0]) begin
              state_d = RDATA;
              sh_d    = rd_data;
              sda_d   = rd_data[7];
            end else begin
              state_d = ADDR_HI;
            end
          end
        end
        ACK_HI: begin
          if (fall_q) begin
            sda_d   = 1'b1;
            state_d = ADDR_LO;
          end
        end
        ACK_LO, WACK: begin
          if (fall_q) begin
            sda_d   = 1'b1;
            state_d = WDATA;
          end
        end
        RDATA: begin
          if (rise_q && !byte_done) begin
            sh_d  = {sh[6:0], 1'b0};
            cnt_d = cnt + 4'd1;
            if (last_bit)
              addr_d = addr + 1'b1;
          end
          if (fall_q) begin
            if (byte_done) begin
              sda_d   = 1'b1;
              cnt_d   = '0;
              state_d = RACK;
            end else begin
              sda_d = sh[7];
            end
          end
        end
        RACK: begin
          // Master's ack bit is parked in sh[0] until the fall.
          if (rise_q)
            sh_d = {7'd0, bit_q};
          if (fall_q) begin
            if (sh[0]) begin
              state_d = IGNORE;
              sda_d   = 1'b1;
            end else begin
              state_d = RDATA;
              sh_d    = rd_data;
              sda_d   = rd_data[7];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sda_out = sda_r;

  eeprom_mem u_mem (
    .clk     (clk),
    .reset   (reset),
    .a_we    (mem_we & reset),
    .a_addr  (addr),
    .a_wdata (wr_byte),
    .a_rdata (rd_data),
    .b_we    (bus.host_we),
    .b_addr  (bus.host_addr),
    .b_wdata (bus.host_wdata),
    .b_rdata (bus.host_rdata)
  );

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Scoreboard bench for i2c_eeprom_slave: a bit-banged master issues
// transfers and queues expected acks/bytes; a monitor compares them.
module tb_i2c_eeprom_slave;
  import eeprom_pkg::*;

  localparam int H = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  i2c_eeprom_slave_if bus ();

  i2c_eeprom_slave #(
    .DEV_ADDR  (7'b1010000),
    .PAGE_BITS (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  string      name_q[$];
  logic [7:0] exp_q[$];
  logic       obs_valid = 1'b0;
  logic [7:0] obs_val = 8'h00;
  int         checks = 0;
  int         passed = 0;
  string      mon_n;
  logic [7:0] mon_e;

  always @(posedge clk) begin
    if (obs_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected: got %02h with no expectation", obs_val);
      end else begin
        mon_n = name_q.pop_front();
        mon_e = exp_q.pop_front();
        if (obs_val === mon_e)
          passed++;
        else
          $display("FAIL %s: got %02h expected %02h", mon_n, obs_val, mon_e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] want);
    name_q.push_back(n);
    exp_q.push_back(want);
    obs_val   = got;
    obs_valid = 1'b1;
    tick(1);
    obs_valid = 1'b0;
  endtask

  task automatic i2c_start;
    bus.sda_in = 1'b1;
    tick(H/2);
    bus.scl = 1'b1;
    tick(H);
    bus.sda_in = 1'b0;
    tick(H);
    bus.scl = 1'b0;
    tick(H/2);
  endtask

  task automatic i2c_stop;
    bus.sda_in = 1'b0;
    tick(H/2);
    bus.scl = 1'b1;
    tick(H);
    bus.sda_in = 1'b1;
    tick(H);
  endtask

  task automatic send_bit(input logic b, input bit col,
                          input logic [12:0] ca, input logic [7:0] cd);
    bus.sda_in = b;
    tick(H/2);
    bus.scl = 1'b1;
    if (col) begin
      tick(2);
      bus.host_addr  = ca;
      bus.host_wdata = cd;
      bus.host_we    = 1'b1;
      tick(1);
      bus.host_we    = 1'b0;
      tick(H-3);
    end else begin
      tick(H);
    end
    bus.scl = 1'b0;
    tick(H/2);
  endtask

  task automatic send_byte(input logic [7:0] b, input string n, input logic ack,
                           input bit col, input logic [12:0] ca, input logic [7:0] cd);
    logic a;
    for (int i = 7; i >= 0; i--)
      send_bit(b[i], col && (i == 0), ca, cd);
    bus.sda_in = 1'b1;
    tick(H/2);
    bus.scl = 1'b1;
    tick(H/2);
    a = bus.sda_out;
    tick(H/2);
    bus.scl = 1'b0;
    tick(H/2);
    chk(n, {7'd0, a}, {7'd0, ack});
  endtask

  task automatic wr(input logic [7:0] b, input string n, input logic ack);
    send_byte(b, n, ack, 1'b0, 13'h0, 8'h00);
  endtask

  task automatic recv_byte(input logic mack, input string n, input logic [7:0] want);
    logic [7:0] d;
    d = 8'h00;
    bus.sda_in = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(H/2);
      bus.scl = 1'b1;
      tick(H/2);
      d[i] = bus.sda_out;
      tick(H/2);
      bus.scl = 1'b0;
    end
    bus.sda_in = mack;
    tick(H/2);
    bus.scl = 1'b1;
    tick(H);
    bus.scl = 1'b0;
    tick(H/2);
    chk(n, d, want);
  endtask

  task automatic host_wr(input logic [12:0] a, input logic [7:0] d);
    bus.host_addr  = a;
    bus.host_wdata = d;
    bus.host_we    = 1'b1;
    tick(1);
    bus.host_we    = 1'b0;
  endtask

  task automatic host_chk(input string n, input logic [12:0] a, input logic [7:0] want);
    bus.host_addr = a;
    tick(2);
    chk(n, bus.host_rdata, want);
  endtask

  initial begin
    reset          = 1'b0;
    bus.scl        = 1'b1;
    bus.sda_in     = 1'b1;
    bus.host_addr  = '0;
    bus.host_we    = 1'b0;
    bus.host_wdata = '0;
    tick(3);
    chk("rst_sda", {7'd0, bus.sda_out}, 8'h01);
    chk("rst_hrd", bus.host_rdata, 8'h00);
    chk("rst_state", 8'(dut.state), 8'(IDLE));
    reset = 1'b1;
    tick(4);

    // random write then read back
    i2c_start();
    wr(8'hA0, "w1_dev", 1'b0);
    wr(8'h01, "w1_ahi", 1'b0);
    wr(8'h23, "w1_alo", 1'b0);
    wr(8'h5A, "w1_dat", 1'b0);
    i2c_stop();
    i2c_start();
    wr(8'hA0, "r1_dev", 1'b0);
    wr(8'h01, "r1_ahi", 1'b0);
    wr(8'h23, "r1_alo", 1'b0);
    i2c_start();
    wr(8'hA1, "r1_devr", 1'b0);
    recv_byte(1'b1, "r1_data", 8'h5A);
    i2c_stop();
    host_chk("h_0123", 13'h0123, 8'h5A);

    // page wrap
    host_wr(13'h0020, 8'h77);
    i2c_start();
    wr(8'hA0, "pw_dev", 1'b0);
    wr(8'h00, "pw_ahi", 1'b0);
    wr(8'h1E, "pw_alo", 1'b0);
    wr(8'h11, "pw_d0", 1'b0);
    wr(8'h22, "pw_d1", 1'b0);
    wr(8'h33, "pw_d2", 1'b0);
    i2c_stop();
    host_chk("pw_1e", 13'h001E, 8'h11);
    host_chk("pw_1f", 13'h001F, 8'h22);
    host_chk("pw_00", 13'h0000, 8'h33);
    host_chk("pw_20", 13'h0020, 8'h77);

    // sequential read across 0x1FFF -> 0x0000
    host_wr(13'h1FFF, 8'hAB);
    host_wr(13'h0000, 8'hCD);
    i2c_start();
    wr(8'hA0, "sr_dev", 1'b0);
    wr(8'h1F, "sr_ahi", 1'b0);
    wr(8'hFF, "sr_alo", 1'b0);
    i2c_start();
    wr(8'hA1, "sr_devr", 1'b0);
    recv_byte(1'b0, "sr_b0", 8'hAB);
    recv_byte(1'b1, "sr_b1", 8'hCD);
    chk("sr_release", {7'd0, bus.sda_out}, 8'h01);
    i2c_stop();

    // wrong device address
    i2c_start();
    wr(8'hA2, "wd_dev", 1'b1);
    wr(8'h00, "wd_b1", 1'b1);
    wr(8'h55, "wd_b2", 1'b1);
    i2c_start();
    wr(8'hA0, "wd_retry", 1'b0);
    i2c_stop();

    // reset after four data bits
    host_wr(13'h0040, 8'h3C);
    i2c_start();
    wr(8'hA0, "rm_dev", 1'b0);
    wr(8'h00, "rm_ahi", 1'b0);
    wr(8'h40, "rm_alo", 1'b0);
    for (int i = 0; i < 4; i++)
      send_bit(1'b1, 1'b0, 13'h0, 8'h00);
    reset = 1'b0;
    tick(1);
    chk("rm_sda", {7'd0, bus.sda_out}, 8'h01);
    chk("rm_state", 8'(dut.state), 8'(IDLE));
    reset = 1'b1;
    bus.sda_in = 1'b1;
    tick(2);
    bus.scl = 1'b1;
    tick(H);
    host_chk("rm_mem", 13'h0040, 8'h3C);

    // address was cleared by reset: current-address read hits 0x0000
    i2c_start();
    wr(8'hA1, "ca_dev", 1'b0);
    recv_byte(1'b1, "ca_data", 8'hCD);
    i2c_stop();

    // host and serial write collide on 0x0050
    i2c_start();
    wr(8'hA0, "co_dev", 1'b0);
    wr(8'h00, "co_ahi", 1'b0);
    wr(8'h50, "co_alo", 1'b0);
    send_byte(8'hC3, "co_ack", 1'b0, 1'b1, 13'h0050, 8'h11);
    i2c_stop();
    host_chk("co_mem", 13'h0050, 8'hC3);

    tick(4);
    checks++;
    if (exp_q.size() == 0)
      passed++;
    else
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

Behavioural model of the 64 Kbit (8 KiB) serial EEPROM on the Pokémon Mini I/O port. It is the responder end of the two-wire protocol that the S1C88 bit-bangs through I/O register 0x2061: bit 3 is SCL and bit 2 is SDA. The block decodes start and stop conditions, the device byte, a 13-bit word address, and data bytes. It stores the data in an internal 8 KiB array. A host port lets the frontend load and save that array.

## Interface
Parameters:
- `DEV_ADDR`, default 7'b1010000: 7-bit device address the block acknowledges.
- `PAGE_BITS`, default 5: write-page size is 2^PAGE_BITS bytes (32).

Ports:
- `clk` in 1: system clock. All logic is on posedge.
- `reset` in 1: synchronous, active-low. reset==0 at a posedge resets the block.
- `scl` in 1: serial clock from the CPU I/O data register, bit 3.
- `sda_in` in 1: SDA level driven by the CPU. The top ties it to 1 when the CPU releases the line.
- `sda_out` out 1: open-drain drive. 0 pulls SDA low; 1 releases it.
- `host_addr` in 13: host array address.
- `host_we` in 1: host write strobe, one byte per cycle.
- `host_wdata` in 8: host write data.
- `host_rdata` out 8: `mem[host_addr]`, registered with 1-cycle latency.

## Operation
- **Input sampling:** `scl` and `sda_in` are registered once as `scl_q` and `sda_q`. The previous values are kept as `scl_qq` and `sda_qq`. All edge and condition detection uses these registers.
- **Condition detection:**
  - Start: `scl_q`=1, `scl_qq`=1, and sda falls.
  - Stop: `scl_q`=1, `scl_qq`=1, and sda rises.
  - Start or stop in any state overrides everything else.
  - Start goes to DEV with the bit count cleared (this covers repeated start). Stop goes to IDLE.
  - Both force `sda_out`=1.
- **Bit timing:** bits are shifted MSB-first on the SCL rising edge. `sda_out` changes only on the SCL falling edge.
- **States:** IDLE, DEV, DEV_ACK, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO, WDATA, WACK, RDATA, RACK, IGNORE.
- **DEV:** after 8 bits, compare the top 7 bits with `DEV_ADDR`.
  - Match: on the next SCL fall drive `sda_out`=0 and enter DEV_ACK.
  - Mismatch: enter IGNORE, which holds `sda_out`=1 until the next start or stop.
- **Leaving DEV_ACK** (at the SCL fall that ends the ack clock):
  - R/W=0 → ADDR_HI.
  - R/W=1 → RDATA, with the shift register loaded from `mem[addr]` and its MSB driven.
- **ADDR_HI:** the 8 received bits go to `addr[12:8]` from bits [4:0]; the upper 3 bits are ignored. Then ACK_HI.
- **ADDR_LO:** the 8 received bits go to `addr[7:0]`. Then ACK_LO, then WDATA.
- **WDATA:**
  - On the 8th rising edge, write `mem[addr]` immediately. There is no busy/write-cycle delay.
  - Then increment only `addr[PAGE_BITS-1:0]`, wrapping within the page.
  - Then WACK (drive 0). Afterwards return to WDATA.
- **RDATA:**
  - After 8 bits, release SDA and enter RACK.
  - Increment `addr` across the full 13-bit range: 0x1FFF → 0x0000.
  - RACK samples the master's bit on the SCL rise.
  - 0 (ack): at the SCL fall, load `mem[addr]` and continue in RDATA.
  - 1 (nack): enter IGNORE, which waits for stop.
- **Current-address read:** after stop, `addr` keeps its value.
- **Host port:** `host_rdata` is available in every state.
  - If `host_we` and the serial write hit the same address in the same cycle, the serial write wins.
  - The array is not cleared by reset.

## Timing
- Reset values:
  - `sda_out`=1, `host_rdata`=0.
  - state=IDLE, `addr`=0, bit count=0, shift register=0.
  - `scl_q`, `scl_qq`, `sda_q`, `sda_qq` = 1.
- Latency from a raw `scl` edge to the detected edge: 2 clk. `sda_out` updates on the 3rd posedge after the raw SCL fall.
- A memory write occurs on the 3rd posedge after the raw SCL rise of bit 8.
- Read data is prefetched from the array continuously using the current `addr`. It is therefore valid long before the SCL fall that loads it; the CPU bit-banging gives ≥ tens of clk per SCL phase.
- SDA changing while SCL is high is never treated as data. It is always a start or stop.
- Reset asserted mid-transaction aborts immediately and releases SDA. A partially received byte is discarded and not written.

## Structure
- A shared package `eeprom_pkg` holds:
  - the state enum `eeprom_state_t`;
  - `EEPROM_ADDR_W` = 13;
  - `EEPROM_DEPTH` = 8192;
  - the default device address.
- One sub-module, `eeprom_mem`: an 8192×8 true-dual-port RAM.
  - Port A: serial side, write plus asynchronous prefetch read.
  - Port B: host side, registered read.
  - Inferable as block RAM.

## Test plan
- **Random write then read:** start, 0xA0, 0x01, 0x23, data 0x5A, stop. Then start, 0xA0, 0x01, 0x23, repeated start, 0xA1, read with nack, stop.
  - Required: ack low on the 3rd and 4th bytes.
  - Required: the read returns 0x5A, and `host_rdata` at 0x0123 = 0x5A.
- **Page wrap:** write 3 bytes 0x11/0x22/0x33 starting at 0x001E.
  - Required: mem[0x1E]=0x11, mem[0x1F]=0x22, mem[0x00]=0x33; mem[0x20] is unchanged.
- **Sequential read wrap:** preload 0x1FFF=0xAB and 0x0000=0xCD via the host port. Set the address to 0x1FFF, then read 2 bytes with ack then nack.
  - Required: 0xAB then 0xCD, and SDA released after the nack.
- **Wrong device:** send 0xA2.
  - Required: `sda_out` stays 1 through the ack clock and the following bytes. The next start with 0xA0 is acked.
- **Reset mid-byte:** reset=0 after 4 data bits of a write.
  - Required: the next cycle has `sda_out`=1 and state IDLE; the memory byte is unchanged.
- **Host/serial collision:** `host_we` to address X in the same cycle as the serial write to X.
  - Required: mem[X] holds the serial value.
